// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package rf_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back requests. Besides the head it exposes a
// per-entry valid/rd view so the top level can answer hazard lookups.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_req_t                       din,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t          mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [DEPTH-1:0] vld;

  // Pointers, occupancy and per-entry valid bits; pushes never target a
  // live entry because the producer is blocked when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign head      = mem[rptr];
  assign ent_valid = vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_rd[i] = mem[i].rd;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter owning the register-file write port. Source A (ALU)
// always wins; source B (load/mul) is queued in rf_wb_fifo and drained when
// A is idle. Optional macro RF_WB_BYPASS_EN lets a B request skip an empty
// FIFO and be written on the next edge.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [4:0]             a_rd,
  input  logic [31:0]            a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [4:0]             b_rd,
  input  logic [31:0]            b_data,
  output logic                   rf_we,
  output logic [4:0]             rf_a3,
  output logic [31:0]            rf_wd3,
  input  logic [4:0]             q_rd,
  output logic                   q_pending,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_req_t                      b_req, head;
  logic                         a_sel, b_fire, b_keep, empty, pop, push, byp;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;

  assign b_req   = '{rd: b_rd, data: b_data};
  assign b_ready = !reset && (fifo_count < FULL);
  assign b_fire  = b_valid && b_ready;
  assign b_keep  = b_fire && (b_rd != '0);
  assign a_sel   = a_valid && (a_rd != '0);
  assign empty   = (fifo_count == '0);
  assign pop     = !a_sel && !empty;
`ifdef RF_WB_BYPASS_EN
  assign byp     = b_keep && empty && !a_sel;
`else
  assign byp     = 1'b0;
`endif
  assign push    = b_keep && !byp;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (b_req),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Hazard lookup over queued entries only; x0 never reports pending.
  always_comb begin
    q_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i] && ent_rd[i] == q_rd) q_pending = 1'b1;
    if (q_rd == '0) q_pending = 1'b0;
  end

  // Registered write port: A, then FIFO head, then bypassed B; address and
  // data hold when no write is selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we  <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
    end else if (a_sel) begin
      rf_we  <= 1'b1;
      rf_a3  <= a_rd;
      rf_wd3 <= a_data;
    end else if (pop) begin
      rf_we  <= 1'b1;
      rf_a3  <= head.rd;
      rf_wd3 <= head.data;
    end else if (byp) begin
      rf_we  <= 1'b1;
      rf_a3  <= b_rd;
      rf_wd3 <= b_data;
    end else begin
      rf_we  <= 1'b0;
    end
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that owns the single write port of the integer register file. It merges two result sources and drives the register file's write port through registered outputs. Source A is single-cycle ALU results: always accepted and highest priority. Source B is multi-cycle load/mul results: valid/ready handshake, buffered in a small FIFO. The block sits between the execute/memory stages and the register file, and exposes a pending-write lookup for the hazard unit.

## Interface
Parameters:
- DEPTH, 4, source-B FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  core clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  source-A write request this cycle
- a_rd  in  5  source-A destination register
- a_data  in  32  source-A result
- b_valid  in  1  source-B request
- b_ready  out  1  source-B accept; transfer when b_valid && b_ready
- b_rd  in  5  source-B destination register
- b_data  in  32  source-B result
- rf_we  out  1  register-file write enable (registered)
- rf_a3  out  5  register-file write address (registered)
- rf_wd3  out  32  register-file write data (registered)
- q_rd  in  5  hazard-unit lookup register
- q_pending  out  1  combinational; 1 if any valid FIFO entry has rd == q_rd and q_rd != 0
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Every cycle, select at most one write:
  - Priority 1: a_valid && a_rd != 0 → write {a_rd, a_data}.
  - Priority 2: FIFO non-empty → pop the head and write it.
  - Otherwise no write.
- Source A never stalls. A request with a_rd == 0 is discarded and does not block the FIFO pop that cycle.
- b_ready = !reset && (fifo_count < DEPTH). Readiness depends only on occupancy: a same-cycle pop does not free a slot for a push.
- A B transfer with b_rd == 0 completes the handshake but is discarded; nothing is pushed.
- Simultaneous push and pop on a non-empty FIFO: the count is unchanged, and the head advances and the tail advances.
- FIFO order is strict; B writes retire in acceptance order.
- Write-after-write ordering between A and B to the same rd is resolved upstream via q_pending. This block performs no reordering.
- The read pointer and write pointer are log2(DEPTH) bits and wrap modulo DEPTH. The count saturates logically at DEPTH because pushes are blocked when full.

## Timing
- Reset values: rf_we=0, rf_a3=0, rf_wd3=0, fifo_count=0, all FIFO entries invalid, q_pending=0, b_ready=0 while reset=1.
- Reset asserted mid-operation discards all FIFO contents on that edge. No write is issued in the cycle after reset.
- Latency:
  - A request at edge N → rf_we=1 from edge N+1.
  - B accepted at edge N, FIFO empty, no A → pushed at N, popped at N+1, rf_we=1 from edge N+2.
- rf_we is deasserted in any cycle with no selected write. rf_a3 and rf_wd3 hold their last values when rf_we=0.
- q_pending reflects FIFO state after the most recent edge. Entries pushed this cycle are not yet visible.

## Configuration
- Macro RF_WB_BYPASS_EN.
- Defined: when the FIFO is empty, the B transfer has b_rd != 0, and no A write is selected, the B request skips the FIFO and is written directly. B latency becomes rf_we=1 from edge N+1, and fifo_count stays 0.
- Undefined: all B requests go through the FIFO, with the 2-cycle minimum latency above.
- With bypass, the bypassed entry is never visible on q_pending.

## Structure
- Package rf_wb_pkg holds:
  - XLEN=32 and REG_AW=5.
  - typedef wb_req_t {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;}.
- Sub-module rf_wb_fifo: parameterised synchronous FIFO of wb_req_t with push, pop, head, count, and a per-entry valid/rd view for the q_pending compare.
- The arbiter's top level holds the priority select, the bypass path and the output registers.

## Test plan
- Reset, then A writes rd=5 data=0xDEADBEEF → one cycle later rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF; the next idle cycle has rf_we=0.
- With A idle, B pushes rd=3/0x11, rd=4/0x22, rd=6/0x33 back-to-back → writes appear in order 3, 4, 6 on consecutive cycles starting edge N+2 (N+1 with bypass for the first).
- A valid continuously for 6 cycles while B pushes 5 entries (DEPTH=4) → b_ready drops after the 4th acceptance and fifo_count=4. After A stops, 4 B writes drain, the 5th is accepted, and all retire in order.
- A to rd=0 in the same cycle as a non-empty FIFO → the FIFO head is written, and no write to x0 occurs. B with b_rd=0 → handshake completes and fifo_count is unchanged.
- FIFO holds rd=7 and q_rd=7 → q_pending=1; q_rd=0 → q_pending=0; after rd=7 retires → q_pending=0.
- Reset asserted with 3 entries queued → next cycle fifo_count=0, rf_we=0, and no queued write ever appears.
